relobi_arbiter: RTL and testbench

Round-robin arbiter that shares one reliable-OBI (relOBI) subordinate port among `NumMgr` relOBI managers. The arbiter votes each manager's triplicated handshake bits and forwards the granted manager's ECC-protected A channel to the subordinate without decoding it. It records the granted manager index in an in-order FIFO and uses that FIFO to steer each R beat back to the right manager. It sits between several relOBI managers (typically `relobi_encoder` outputs) and one `relobi_decoder` or relOBI subordinate.

---
 rtl/relobi_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_relobi_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relobi_arbiter.sv
// relobi_arbiter: round-robin arbiter sharing one reliable-OBI subordinate port among NumMgr
// managers.
//
// The triplicated handshake bits (req, rready, gnt, rvalid) are majority-voted. The
// ECC-protected A and R channels are forwarded bit-exact without being decoded. A FIFO keeps
// the accepted manager indices in order, and each R beat is steered back to the manager at
// the FIFO head.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   mgr_req_i  per-manager relOBI requests
//   mgr_rsp_o  per-manager relOBI responses
//   sbr_req_o  request to the shared subordinate
//   sbr_rsp_i  response from the shared subordinate
//   fault_o    combinational pulse on any voter mismatch or on an R beat with no owner
//
// Build option: define RELOBI_ARBITER_FIFO_TMR_EN to triplicate the index FIFO storage,
// pointers and count. Each copy is read through a majority voter.

package relobi_arbiter_pkg;

  typedef struct packed {
    bit UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1};

  // Widths of the opaque, ECC-protected A and R payloads.
  localparam int unsigned AWidth = 84;
  localparam int unsigned RWidth = 45;

  typedef struct packed {
    logic [2:0]        req;
    logic [AWidth-1:0] a;
    logic [2:0]        rready;
  } relobi_req_t;

  typedef struct packed {
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [RWidth-1:0] r;
  } relobi_rsp_t;

endpackage

module relobi_arbiter #(
  parameter relobi_arbiter_pkg::obi_cfg_t Cfg = relobi_arbiter_pkg::ObiDefaultConfig,
  parameter int unsigned NumMgr   = 2,
  parameter int unsigned MaxTrans = 4,
  parameter type relobi_req_t = relobi_arbiter_pkg::relobi_req_t,
  parameter type relobi_rsp_t = relobi_arbiter_pkg::relobi_rsp_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  relobi_req_t [NumMgr-1:0] mgr_req_i,
  output relobi_rsp_t [NumMgr-1:0] mgr_rsp_o,
  output relobi_req_t              sbr_req_o,
  input  relobi_rsp_t              sbr_rsp_i,
  output logic                     fault_o
);

  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  function automatic logic maj3(logic [2:0] x);
    return (x[0] & x[1]) | (x[1] & x[2]) | (x[0] & x[2]);
  endfunction

  function automatic logic mm3(logic [2:0] x);
    return (x != 3'b000) && (x != 3'b111);
  endfunction

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake voting
  logic [NumMgr-1:0] req_v, rready_v, req_mm, rready_mm;
  logic              gnt_v, rvalid_v, gnt_mm, rvalid_mm;

  always_comb begin
    for (int i = 0; i < int'(NumMgr); i++) begin
      req_v[i]     = maj3(mgr_req_i[i].req);
      req_mm[i]    = mm3(mgr_req_i[i].req);
      rready_v[i]  = maj3(mgr_req_i[i].rready);
      rready_mm[i] = mm3(mgr_req_i[i].rready);
    end
    gnt_v     = maj3(sbr_rsp_i.gnt);
    gnt_mm    = mm3(sbr_rsp_i.gnt);
    rvalid_v  = maj3(sbr_rsp_i.rvalid);
    rvalid_mm = mm3(sbr_rsp_i.rvalid);
  end

  // FIFO view shared by both storage variants
  ptr_t wr_ptr_v, rd_ptr_v, wr_ptr_d, rd_ptr_d;
  cnt_t count_v, count_d;
  idx_t mem_v [MaxTrans];
  idx_t head;
  logic fifo_fault;
  logic full, empty, push, pop;

  assign full  = (count_v == cnt_t'(MaxTrans));
  assign empty = (count_v == '0);
  assign head  = mem_v[rd_ptr_v];

  // Arbitration
  idx_t rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, winner, sel;
  logic locked_q, locked_d, any_req, has_cand, sel_req, accept;

  // First requester at or above rr_ptr wins; otherwise the lowest requester (wrap-around).
  always_comb begin
    logic hi_any;
    idx_t hi_win;
    winner  = '0;
    any_req = 1'b0;
    hi_any  = 1'b0;
    hi_win  = '0;
    for (int i = int'(NumMgr) - 1; i >= 0; i--) begin
      if (req_v[i]) begin
        any_req = 1'b1;
        winner  = idx_t'(i);
        if (idx_t'(i) >= rr_ptr_q) begin
          hi_any = 1'b1;
          hi_win = idx_t'(i);
        end
      end
    end
    if (hi_any) begin
      winner = hi_win;
    end
  end

  // A pending, ungranted request pins the selection so the forwarded A channel stays stable.
  always_comb begin
    sel        = locked_q ? lock_idx_q : winner;
    has_cand   = locked_q ? req_v[lock_idx_q] : any_req;
    sel_req    = has_cand & ~full;
    accept     = sel_req & gnt_v;
    locked_d   = has_cand & ~accept;
    lock_idx_d = sel;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (sel == idx_t'(NumMgr - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Forwarding and response routing
  logic head_rready, route_err;

  assign head_rready = Cfg.UseRReady ? rready_v[head] : 1'b1;
  assign push        = accept;
  assign pop         = rvalid_v & ~empty & head_rready;
  assign route_err   = rvalid_v & empty;

  always_comb begin
    sbr_req_o     = mgr_req_i[sel];
    sbr_req_o.req = {3{sel_req}};
    // An ownerless beat is drained unconditionally.
    sbr_req_o.rready = empty ? 3'b111 : {3{head_rready}};
    for (int i = 0; i < int'(NumMgr); i++) begin
      mgr_rsp_o[i]        = sbr_rsp_i;
      mgr_rsp_o[i].gnt    = {3{accept && (sel == idx_t'(i))}};
      mgr_rsp_o[i].rvalid = {3{rvalid_v && !empty && (head == idx_t'(i))}};
    end
  end

  assign fault_o = (|req_mm) | (|rready_mm) | gnt_mm | rvalid_mm | route_err | fifo_fault;

  // FIFO next state
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_v) : wr_ptr_v;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_v) : rd_ptr_v;
    case ({push, pop})
      2'b10:   count_d = count_v + 1'b1;
      2'b01:   count_d = count_v - 1'b1;
      default: count_d = count_v;
    endcase
  end

`ifdef RELOBI_ARBITER_FIFO_TMR_EN
  ptr_t wr_ptr_q [3];
  ptr_t rd_ptr_q [3];
  cnt_t count_q  [3];
  idx_t mem_q    [3][MaxTrans];

  always_comb begin
    fifo_fault = 1'b0;
    wr_ptr_v   = (wr_ptr_q[0] & wr_ptr_q[1]) | (wr_ptr_q[1] & wr_ptr_q[2]) |
                 (wr_ptr_q[0] & wr_ptr_q[2]);
    fifo_fault |= (wr_ptr_q[0] != wr_ptr_q[1]) || (wr_ptr_q[1] != wr_ptr_q[2]);
    rd_ptr_v   = (rd_ptr_q[0] & rd_ptr_q[1]) | (rd_ptr_q[1] & rd_ptr_q[2]) |
                 (rd_ptr_q[0] & rd_ptr_q[2]);
    fifo_fault |= (rd_ptr_q[0] != rd_ptr_q[1]) || (rd_ptr_q[1] != rd_ptr_q[2]);
    count_v    = (count_q[0] & count_q[1]) | (count_q[1] & count_q[2]) |
                 (count_q[0] & count_q[2]);
    fifo_fault |= (count_q[0] != count_q[1]) || (count_q[1] != count_q[2]);
    for (int k = 0; k < int'(MaxTrans); k++) begin
      mem_v[k] = (mem_q[0][k] & mem_q[1][k]) | (mem_q[1][k] & mem_q[2][k]) |
                 (mem_q[0][k] & mem_q[2][k]);
      fifo_fault |= (mem_q[0][k] != mem_q[1][k]) || (mem_q[1][k] != mem_q[2][k]);
    end
  end

  // Every copy is rewritten from the voted value each cycle, scrubbing single upsets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 3; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
        for (int k = 0; k < int'(MaxTrans); k++) begin
          mem_q[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        wr_ptr_q[c] <= wr_ptr_d;
        rd_ptr_q[c] <= rd_ptr_d;
        count_q[c]  <= count_d;
        for (int k = 0; k < int'(MaxTrans); k++) begin
          mem_q[c][k] <= (push && (wr_ptr_v == ptr_t'(k))) ? sel : mem_v[k];
        end
      end
    end
  end
`else
  ptr_t wr_ptr_q, rd_ptr_q;
  cnt_t count_q;
  idx_t mem_q [MaxTrans];

  assign wr_ptr_v   = wr_ptr_q;
  assign rd_ptr_v   = rd_ptr_q;
  assign count_v    = count_q;
  assign mem_v      = mem_q;
  assign fifo_fault = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < int'(MaxTrans); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= sel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_relobi_arbiter.sv
module tb_relobi_arbiter;
  import relobi_arbiter_pkg::*;

  localparam int unsigned NumMgr   = 3;
  localparam int unsigned MaxTrans = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relobi_req_t [NumMgr-1:0] mgr_req;
  relobi_rsp_t [NumMgr-1:0] mgr_rsp;
  relobi_req_t              sbr_req;
  relobi_rsp_t              sbr_rsp;
  logic                     fault;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  relobi_arbiter #(
    .Cfg          (ObiDefaultConfig),
    .NumMgr       (NumMgr),
    .MaxTrans     (MaxTrans),
    .relobi_req_t (relobi_req_t),
    .relobi_rsp_t (relobi_rsp_t)
  ) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .mgr_req_i (mgr_req),
    .mgr_rsp_o (mgr_rsp),
    .sbr_req_o (sbr_req),
    .sbr_rsp_i (sbr_rsp),
    .fault_o   (fault)
  );

  logic [8:0] gnt_all, rvalid_all;
  assign gnt_all    = {mgr_rsp[2].gnt, mgr_rsp[1].gnt, mgr_rsp[0].gnt};
  assign rvalid_all = {mgr_rsp[2].rvalid, mgr_rsp[1].rvalid, mgr_rsp[0].rvalid};

  function automatic logic [8:0] onehot3(int idx);
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == idx) v[3*i +: 3] = 3'b111;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard and checks the current beat lands on that manager only.
  task automatic chk_route(input string tag);
    int h;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s observed beat expected no beat (scoreboard empty)", tag);
    end
    if (exp_q.size() > 0) begin
      h = exp_q.pop_front();
      chk({tag, "_rvalid"}, 128'(rvalid_all), 128'(onehot3(h)));
      chk({tag, "_r"}, 128'(mgr_rsp[h].r), 128'(sbr_rsp.r));
    end
  endtask

  task automatic idle();
    for (int m = 0; m < int'(NumMgr); m++) begin
      mgr_req[m].req    = 3'b000;
      mgr_req[m].rready = 3'b111;
    end
    sbr_rsp.gnt    = 3'b000;
    sbr_rsp.rvalid = 3'b000;
    sbr_rsp.r      = RWidth'({$urandom(), $urandom()});
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int m = 0; m < int'(NumMgr); m++) begin
      mgr_req[m].a = AWidth'({$urandom(), $urandom(), $urandom()});
    end
    idle();

    // Reset state
    #3;
    chk("rst_req", 128'(sbr_req.req), 128'(3'b000));
    chk("rst_gnt", 128'(gnt_all), 128'(9'h0));
    chk("rst_rvalid", 128'(rvalid_all), 128'(9'h0));
    chk("rst_fault", 128'(fault), 128'(1'b0));
    next();
    rst_n = 1'b1;
    next();

    // Fairness: everyone requests, gnt always high, each beat returned one cycle later
    for (int k = 0; k < 6; k++) begin
      idle();
      for (int m = 0; m < int'(NumMgr); m++) mgr_req[m].req = 3'b111;
      sbr_rsp.gnt    = 3'b111;
      sbr_rsp.rvalid = (exp_q.size() > 0) ? 3'b111 : 3'b000;
      settle();
      chk("fair_gnt", 128'(gnt_all), 128'(onehot3(k % 3)));
      chk("fair_a", 128'(sbr_req.a), 128'(mgr_req[k % 3].a));
      chk("fair_fault", 128'(fault), 128'(1'b0));
      if (sbr_rsp.rvalid == 3'b111) chk_route("fair_route");
      exp_q.push_back(k % 3);
      next();
    end
    idle();
    sbr_rsp.rvalid = 3'b111;
    settle();
    chk_route("fair_drain");
    next();

    // Lock: manager 1 waits for gnt, manager 0 joins and must not steal the selection
    idle();
    mgr_req[1].req = 3'b111;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("lock_req", 128'(sbr_req.req), 128'(3'b111));
      chk("lock_a", 128'(sbr_req.a), 128'(mgr_req[1].a));
      chk("lock_nognt", 128'(gnt_all), 128'(9'h0));
      next();
    end
    mgr_req[0].req = 3'b111;
    settle();
    chk("lock_hold_a", 128'(sbr_req.a), 128'(mgr_req[1].a));
    next();
    sbr_rsp.gnt = 3'b111;
    settle();
    chk("lock_gnt1", 128'(gnt_all), 128'(onehot3(1)));
    exp_q.push_back(1);
    next();
    mgr_req[1].req = 3'b000;
    sbr_rsp.rvalid = 3'b111;
    settle();
    chk("lock_gnt0", 128'(gnt_all), 128'(onehot3(0)));
    chk_route("lock_route1");
    exp_q.push_back(0);
    next();
    idle();
    sbr_rsp.rvalid = 3'b111;
    settle();
    chk_route("lock_route0");
    next();

    // Routing and full-stall
    idle();
    mgr_req[0].req = 3'b111;
    sbr_rsp.gnt    = 3'b111;
    settle();
    chk("full_gnt0", 128'(gnt_all), 128'(onehot3(0)));
    exp_q.push_back(0);
    next();
    idle();
    mgr_req[1].req = 3'b111;
    sbr_rsp.gnt    = 3'b111;
    settle();
    chk("full_gnt1", 128'(gnt_all), 128'(onehot3(1)));
    exp_q.push_back(1);
    next();
    idle();
    mgr_req[2].req = 3'b111;
    sbr_rsp.gnt    = 3'b111;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("full_stall_req", 128'(sbr_req.req), 128'(3'b000));
      chk("full_stall_gnt", 128'(gnt_all), 128'(9'h0));
      next();
    end
    sbr_rsp.rvalid = 3'b111;
    settle();
    chk_route("full_route0");
    chk("full_pop_req", 128'(sbr_req.req), 128'(3'b000));
    chk("full_pop_gnt", 128'(gnt_all), 128'(9'h0));
    next();
    settle();
    chk_route("full_route1");
    chk("full_free_req", 128'(sbr_req.req), 128'(3'b111));
    chk("full_free_gnt", 128'(gnt_all), 128'(onehot3(2)));
    exp_q.push_back(2);
    next();
    idle();
    mgr_req[2].rready = 3'b000;
    sbr_rsp.rvalid    = 3'b111;
    settle();
    chk("rr_low_rready", 128'(sbr_req.rready), 128'(3'b000));
    chk("rr_low_rvalid", 128'(rvalid_all), 128'(onehot3(2)));
    next();
    mgr_req[2].rready = 3'b111;
    settle();
    chk("rr_high_rready", 128'(sbr_req.rready), 128'(3'b111));
    chk_route("rr_route2");
    next();

    // Voter faults
    idle();
    mgr_req[0].req = 3'b011;
    sbr_rsp.gnt    = 3'b111;
    settle();
    chk("vote_req_gnt", 128'(gnt_all), 128'(onehot3(0)));
    chk("vote_req_sbr", 128'(sbr_req.req), 128'(3'b111));
    chk("vote_req_fault", 128'(fault), 128'(1'b1));
    exp_q.push_back(0);
    next();
    idle();
    sbr_rsp.rvalid = 3'b111;
    settle();
    chk_route("vote_route0");
    chk("vote_clean_fault", 128'(fault), 128'(1'b0));
    next();
    idle();
    mgr_req[1].req = 3'b111;
    sbr_rsp.gnt    = 3'b001;
    settle();
    chk("vote_gnt_none", 128'(gnt_all), 128'(9'h0));
    chk("vote_gnt_fault", 128'(fault), 128'(1'b1));
    next();
    sbr_rsp.gnt = 3'b111;
    settle();
    chk("vote_gnt1", 128'(gnt_all), 128'(onehot3(1)));
    chk("vote_gnt1_fault", 128'(fault), 128'(1'b0));
    exp_q.push_back(1);
    next();
    idle();
    sbr_rsp.rvalid = 3'b101;
    settle();
    chk_route("vote_rvalid_route");
    chk("vote_rvalid_fault", 128'(fault), 128'(1'b1));
    next();

    // Spurious response with an empty FIFO
    idle();
    for (int m = 0; m < int'(NumMgr); m++) mgr_req[m].rready = 3'b000;
    sbr_rsp.rvalid = 3'b111;
    settle();
    chk("spur_rvalid", 128'(rvalid_all), 128'(9'h0));
    chk("spur_rready", 128'(sbr_req.rready), 128'(3'b111));
    chk("spur_fault", 128'(fault), 128'(1'b1));
    next();

    // Reset with two transactions outstanding
    idle();
    mgr_req[0].req = 3'b111;
    sbr_rsp.gnt    = 3'b111;
    settle();
    chk("mid_gnt0", 128'(gnt_all), 128'(onehot3(0)));
    next();
    idle();
    mgr_req[1].req = 3'b111;
    sbr_rsp.gnt    = 3'b111;
    settle();
    chk("mid_gnt1", 128'(gnt_all), 128'(onehot3(1)));
    next();
    idle();
    rst_n = 1'b0;
    exp_q.delete();
    settle();
    chk("mid_rst_req", 128'(sbr_req.req), 128'(3'b000));
    chk("mid_rst_gnt", 128'(gnt_all), 128'(9'h0));
    chk("mid_rst_rvalid", 128'(rvalid_all), 128'(9'h0));
    chk("mid_rst_fault", 128'(fault), 128'(1'b0));
    next();
    rst_n = 1'b1;
    next();
    for (int m = 0; m < int'(NumMgr); m++) mgr_req[m].req = 3'b111;
    sbr_rsp.gnt = 3'b111;
    settle();
    chk("post_rst_gnt", 128'(gnt_all), 128'(onehot3(0)));
    exp_q.push_back(0);
    next();
    idle();
    sbr_rsp.rvalid = 3'b111;
    settle();
    chk_route("post_rst_route");
    chk("post_rst_fault", 128'(fault), 128'(1'b0));
    next();
    settle();
    chk("post_rst_spur_rvalid", 128'(rvalid_all), 128'(9'h0));
    chk("post_rst_spur_fault", 128'(fault), 128'(1'b1));
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
